// File: rtl/legv8_pkg.sv
// legv8_pkg
// Shared LEGv8 encoding table: micro-op kind codes, the 11-bit R/D-type
// opcodes and the 8-bit CB-type opcode. The control-unit decoder imports
// the same package, so the encoder and decoder always use the same encodings.
// Also holds two small helpers used by the encoder's reject logic.
package legv8_pkg;

  // Micro-op kinds as presented on in_op (code 7 is reserved)
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ORR  = 3'd3;
  localparam logic [2:0] OP_LDUR = 3'd4;
  localparam logic [2:0] OP_STUR = 3'd5;
  localparam logic [2:0] OP_CBZ  = 3'd6;

  // Opcodes placed in instr[31:21]
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // CB-type opcode placed in instr[31:24]
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  // Loads and stores carry a 9-bit DT_address
  function automatic logic is_dtype(input logic [2:0] op);
    return (op == OP_LDUR) || (op == OP_STUR);
  endfunction

  // A 19-bit signed value fits in 9 signed bits when its upper bits [18:8]
  // are all copies of the sign, i.e. all ones or all zeros
  function automatic logic d_imm_fits(input logic [18:0] imm);
    return (&imm[18:8]) | ~(|imm[18:8]);
  endfunction

endpackage

// File: rtl/legv8_instr_fifo.sv
// legv8_instr_fifo
// Small instruction-word FIFO with a valid/ready read side and a registered
// head word. The head is kept in its own register, so the output word comes
// straight from a flop and stays stable while the consumer stalls.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   push           write push_data this cycle (caller guarantees !full)
//   push_data      word to enqueue
//   full           all DEPTH slots occupied
//   out_valid      head holds a valid word
//   out_ready      consumer takes the head word when out_valid & out_ready
//   head           registered head-of-queue word
module legv8_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic [PW:0]      count;
  logic             pop;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign rd_next   = rd_ptr + PW'(1);

  // Storage array; it needs no reset because count decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the head register. On a pop the head reloads
  // from the next slot, or from the incoming word when only one entry was
  // queued. A push into an empty queue loads the head directly, which gives
  // the one-edge latency from accept to out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      if (pop) begin
        if (count == ONE_CNT) begin
          if (push) begin
            head <= push_data;
          end
        end else begin
          head <= mem[rd_next];
        end
      end else if (push && (count == '0)) begin
        head <= push_data;
      end
    end
  end

  // The handshake should make these impossible; flag them if they ever happen
  assert property (@(posedge clk) disable iff (reset) !(push && full));
  assert property (@(posedge clk) disable iff (reset) !(pop && !out_valid));

endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
// Turns micro-op requests into 32-bit LEGv8 instruction words and queues
// them for a valid/ready consumer. Requests that cannot be encoded (the
// reserved op, or a load/store whose offset needs more than 9 bits) still
// complete the handshake. They are dropped and counted instead of queued.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready = FIFO not full)
//   in_op,in_rd,in_rn,in_rm,in_imm   request fields
//   out_valid/out_ready word stream handshake
//   out_instr           registered encoded word at the FIFO head
//   out_opcode          out_instr[31:21], for the control unit
//   rej_pulse           one-cycle pulse after a rejected request is accepted
//   rej_count           saturating count of rejected requests
module legv8_instr_encoder
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rn,
  input  logic [4:0]       in_rm,
  input  logic [18:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [10:0]      out_opcode,
  output logic             rej_pulse,
  output logic [CNT_W-1:0] rej_count
);

  logic [31:0] enc_word;
  logic        op_bad;
  logic        is_reject;
  logic        accept;
  logic        push;
  logic        fifo_full;

  // Encode the request fields into a word. R-type always uses shamt 0.
  // The D-type form takes only the low 9 immediate bits; range is checked
  // separately.
  always_comb begin
    enc_word = '0;
    op_bad   = 1'b0;
    case (in_op)
      OP_ADD:  enc_word = {OPC_ADD, in_rm, 6'b0, in_rn, in_rd};
      OP_SUB:  enc_word = {OPC_SUB, in_rm, 6'b0, in_rn, in_rd};
      OP_AND:  enc_word = {OPC_AND, in_rm, 6'b0, in_rn, in_rd};
      OP_ORR:  enc_word = {OPC_ORR, in_rm, 6'b0, in_rn, in_rd};
      OP_LDUR: enc_word = {OPC_LDUR, in_imm[8:0], 2'b00, in_rn, in_rd};
      OP_STUR: enc_word = {OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
      OP_CBZ:  enc_word = {OPC_CBZ, in_imm, in_rd};
      default: op_bad   = 1'b1;
    endcase
  end

  assign is_reject = op_bad | (is_dtype(in_op) & ~d_imm_fits(in_imm));
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~is_reject;
  assign in_ready  = ~fifo_full;

  legv8_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (enc_word),
    .full      (fifo_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .head      (out_instr)
  );

  assign out_opcode = out_instr[31:21];

  // Reject reporting: the pulse follows the accepting edge by one cycle,
  // and the counter stops at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rej_pulse <= 1'b0;
      rej_count <= '0;
    end else begin
      rej_pulse <= accept & is_reject;
      if (accept && is_reject && (rej_count != '1)) begin
        rej_count <= rej_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder
// Directed bench for legv8_instr_encoder: a table of single requests with
// hand-computed words, then hand-written sequences for back-pressure,
// streaming and reset while words are queued.
module tb_legv8_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [4:0]       in_rd;
  logic [4:0]       in_rn;
  logic [4:0]       in_rm;
  logic [18:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [10:0]      out_opcode;
  logic             rej_pulse;
  logic [CNT_W-1:0] rej_count;

  int total = 0;
  int bad   = 0;
  int exp_rej = 0;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [18:0] imm;
    logic        rej;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [13];

  legv8_instr_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_rm      (in_rm),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .rej_pulse  (rej_pulse),
    .rej_count  (rej_count)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request on the input side
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rd,
                               input logic [4:0] rn, input logic [4:0] rm,
                               input logic [18:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rn    = rn;
    in_rm    = rm;
    in_imm   = imm;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    // Request table: op, rd, rn, rm, imm, rejected, expected word
    vecs[0]  = '{3'd0, 5'd3,  5'd1,  5'd2,  19'h00000, 1'b0, 32'h8B020023};
    vecs[1]  = '{3'd4, 5'd5,  5'd2,  5'd7,  19'h00008, 1'b0, 32'hF8408045};
    vecs[2]  = '{3'd5, 5'd5,  5'd2,  5'd0,  19'h7FFF8, 1'b0, 32'hF81F8045};
    vecs[3]  = '{3'd1, 5'd0,  5'd0,  5'd0,  19'h00000, 1'b0, 32'hCB000000};
    vecs[4]  = '{3'd6, 5'd9,  5'd31, 5'd31, 19'h7FFFC, 1'b0, 32'hB4FFFF89};
    vecs[5]  = '{3'd4, 5'd5,  5'd2,  5'd0,  19'h00100, 1'b1, 32'h0};
    vecs[6]  = '{3'd7, 5'd1,  5'd1,  5'd1,  19'h00001, 1'b1, 32'h0};
    vecs[7]  = '{3'd2, 5'd31, 5'd30, 5'd29, 19'h00000, 1'b0, 32'h8A1D03DF};
    vecs[8]  = '{3'd3, 5'd1,  5'd2,  5'd3,  19'h00000, 1'b0, 32'hAA030041};
    vecs[9]  = '{3'd4, 5'd0,  5'd0,  5'd0,  19'h000FF, 1'b0, 32'hF84FF000};
    vecs[10] = '{3'd5, 5'd31, 5'd31, 5'd0,  19'h7FF00, 1'b0, 32'hF81003FF};
    vecs[11] = '{3'd5, 5'd31, 5'd31, 5'd0,  19'h7FEFF, 1'b1, 32'h0};
    vecs[12] = '{3'd6, 5'd0,  5'd0,  5'd0,  19'h40000, 1'b0, 32'hB4800000};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_rn     = '0;
    in_rm     = '0;
    in_imm    = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_instr", out_instr, 0);
    checkOutput("rst_out_opcode", out_opcode, 0);
    checkOutput("rst_rej_pulse", rej_pulse, 0);
    checkOutput("rst_rej_count", rej_count, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);

    // Table: one request at a time, checked one edge later, then drained
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
      @(negedge clk);
      in_valid = 1'b0;
      if (vecs[i].rej) exp_rej++;
      checkOutput($sformatf("vec%0d_out_valid", i), out_valid, !vecs[i].rej);
      checkOutput($sformatf("vec%0d_rej_pulse", i), rej_pulse, vecs[i].rej);
      checkOutput($sformatf("vec%0d_rej_count", i), rej_count, exp_rej);
      if (!vecs[i].rej) begin
        checkOutput($sformatf("vec%0d_instr", i), out_instr, vecs[i].word);
        checkOutput($sformatf("vec%0d_opcode", i), out_opcode, vecs[i].word[31:21]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput($sformatf("vec%0d_drained", i), out_valid, 0);
      checkOutput($sformatf("vec%0d_pulse_clear", i), rej_pulse, 0);
    end

    // Back-pressure: in_ready must drop once DEPTH words are queued
    out_ready = 1'b0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      applyStimulus(3'd0, 5'(c), 5'd1, 5'd2, 19'h0);
      checkOutput($sformatf("bp_in_ready%0d", c), in_ready, (c < DEPTH) ? 1 : 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("bp_head_stable", out_instr, 32'h8B020020);
    begin
      int got;
      got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (out_valid) begin
          checkOutput($sformatf("bp_drain%0d", got), out_instr, 32'h8B020020 | got);
          got++;
        end
        @(negedge clk);
      end
      checkOutput("bp_drain_count", got, DEPTH);
    end

    // Streaming: push and pop together every cycle, one word per cycle
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        checkOutput($sformatf("st_valid%0d", i - 1), out_valid, 1);
        checkOutput($sformatf("st_instr%0d", i - 1), out_instr,
                    {11'b10001011000, 5'd0, 6'd0, 5'(i), 5'(i - 1)});
        checkOutput($sformatf("st_in_ready%0d", i - 1), in_ready, 1);
      end
      if (i < 20) applyStimulus(3'd0, 5'(i), 5'(i + 1), 5'd0, 19'h0);
      else in_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("st_empty", out_valid, 0);

    // Reset with words queued: everything is discarded at once
    out_ready = 1'b0;
    applyStimulus(3'd6, 5'd1, 5'd0, 5'd0, 19'h00010);
    @(negedge clk);
    applyStimulus(3'd7, 5'd0, 5'd0, 5'd0, 19'h0);
    @(negedge clk);
    applyStimulus(3'd1, 5'd2, 5'd3, 5'd4, 19'h0);
    @(negedge clk);
    applyStimulus(3'd2, 5'd5, 5'd6, 5'd7, 19'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("rm_pre_valid", out_valid, 1);
    checkOutput("rm_pre_rej", rej_count, exp_rej + 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rm_valid_now", out_valid, 0);
    checkOutput("rm_rej_count_now", rej_count, 0);
    checkOutput("rm_instr_now", out_instr, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_rej = 0;
    @(negedge clk);
    checkOutput("rm_post_valid", out_valid, 0);
    checkOutput("rm_post_ready", in_ready, 1);
    checkOutput("rm_post_rej", rej_count, 0);
    applyStimulus(3'd0, 5'd7, 5'd1, 5'd2, 19'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("rm_new_valid", out_valid, 1);
    checkOutput("rm_new_instr", out_instr, 32'h8B020027);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rm_new_drained", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
